nx1_ppi_master: RTL and testbench
=================================

Name: nx1_ppi_master

Overview:
- Synchronous bus initiator that drives the CPU side of an 8255-compatible PIA (nx1 PIA block).
- Converts one-command-at-a-time valid/ready requests into properly timed CS/WR/RD/A/D bus cycles with programmable setup, strobe, hold and recovery times.
- Captures read data and signals completion.
- Sits between the X1 core's internal sequencer (keyboard, printer and IPL control) and the PIA bus pins.

Parameters:
- T_SETUP, 1: cycles CS/A/D are stable before the strobe; 0..15, 0 skips the phase.
- T_PULSE, 2: cycles WR or RD is high; 1..15. A value of 0 is illegal and is treated as 1.
- T_HOLD, 1: cycles CS/A/D are held after the strobe falls; 0..15. The PIA latches on the falling edge of CS&WR, so this hold is mandatory for writes.
- T_RECOVER, 1: cycles CS is low between transactions; 0..15.

Ports:
- I_CLK  in  1  system clock
- I_RESET  in  1  reset
- I_CMD_VALID  in  1  command request
- O_CMD_READY  out  1  command accepted when high together with I_CMD_VALID
- I_CMD_OP  in  2  00 write reg, 01 read reg, 10 PC bit set/reset, 11 mode set
- I_CMD_ADDR  in  2  register select (ops 00/01 only)
- I_CMD_DATA  in  8  write data, bit-op or mode payload
- O_DONE  out  1  one-cycle pulse when a transaction ends
- O_RDATA  out  8  last read data
- O_A  out  2  PIA address
- O_CS  out  1  PIA chip select, active-high
- O_WR  out  1  PIA write strobe, active-high
- O_RD  out  1  PIA read strobe, active-high
- O_D  out  8  PIA write data
- I_D  in  8  PIA read data

Behaviour:
- Reset: I_RESET, asynchronous, active-high. While asserted and on exit:
  - O_CS, O_WR, O_RD, O_DONE = 0
  - O_A = 2'b00, O_D = 8'h00, O_RDATA = 8'h00
  - FSM in IDLE, O_CMD_READY = 1
- All outputs are registered.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER.
- IDLE:
  - O_CMD_READY = 1.
  - On I_CMD_VALID, latch the command.
  - Next state is SETUP, or STROBE if T_SETUP = 0.
- Bus address/data mapping, driven from the first non-IDLE cycle:
  - op 00: O_A = ADDR, O_D = DATA.
  - op 01: O_A = ADDR; O_D holds its previous value.
  - op 10: O_A = 2'b11, O_D = {4'b0000, DATA[3:1], DATA[0]} (bit index, value).
  - op 11: O_A = 2'b11, O_D = {1'b1, DATA[6:0]}.
- SETUP (T_SETUP cycles): O_CS = 1, strobes 0.
- STROBE (T_PULSE cycles): O_CS = 1.
  - O_WR = 1 for ops 00/10/11; O_RD = 1 for op 01.
  - Reads: I_D is sampled into O_RDATA at the clock edge ending the last STROBE cycle.
- HOLD (T_HOLD cycles): strobes 0; O_CS, O_A, O_D unchanged.
- RECOVER (T_RECOVER cycles): O_CS = 0; O_A/O_D keep their values.
- Phase skipping: any phase whose parameter is 0 is skipped and the FSM goes straight to the next phase.
- Return to IDLE: O_DONE = 1 for exactly the first IDLE cycle.
  - A new command may be accepted in that same cycle.
  - Back-to-back period = 1 + T_SETUP + T_PULSE + T_HOLD + T_RECOVER cycles (6 with defaults).
- O_CMD_READY = 0 in every non-IDLE state. I_CMD_* are ignored there and need not be held stable after acceptance.
- O_RDATA changes only on read capture. Writes do not alter it.
- Reset mid-transaction: strobes and CS drop immediately and asynchronously; no O_DONE is produced; O_RDATA is cleared.
- O_WR and O_RD are never high simultaneously. No strobe is ever high while O_CS = 0.

Decomposition:
- Package nx1_ppi_pkg holds:
  - op codes: OP_WR, OP_RD, OP_BSR, OP_MODE
  - PIA register addresses: PA = 0, PB = 1, PC = 2, CTRL = 3
  - FSM state enum
  - 4-bit timer width constant
- Sub-module nx1_ppi_timer: 4-bit load/decrement counter with a zero flag, used to time each phase.

Test Plan:
- Reset, then write op 00, ADDR = 1, DATA = 8'hA5, defaults:
  - cycle 1: CS = 1, A = 1, D = A5
  - cycles 2-3: WR = 1
  - cycle 4: WR = 0, CS = 1
  - cycle 5: CS = 0
  - cycle 6: DONE = 1, READY = 1
- Read op 01, ADDR = 2, with I_D = 8'h3C held during STROBE then changed to 8'hFF in HOLD -> O_RDATA = 3C after DONE; RD high exactly 2 cycles; WR stays 0.
- Bit op 10 with DATA = 8'h0B -> A = 3, D = 8'h0B; op 11 with DATA = 8'h12 -> A = 3, D = 8'h92; PIA model shows PC bit 5 set and mode word latched.
- I_CMD_VALID held high for 3 commands -> accepts 6 cycles apart; DONE and READY coincide; no CS gap shorter than T_RECOVER.
- Parameters T_SETUP = 0, T_HOLD = 0, T_RECOVER = 0, T_PULSE = 1 -> 2-cycle period; strobe never high with CS low.
- Assert I_RESET during the second STROBE cycle -> CS/WR low in the same cycle, no DONE, O_RDATA = 00, READY = 1 after release.

Source files
------------

// File: rtl/nx1_ppi_pkg.sv
// Shared types and constants for the nx1 PIA bus initiator.
// Op codes, PIA register map, FSM states and the command-to-bus mapping.
package nx1_ppi_pkg;

  localparam int unsigned TMR_W = 4;

  typedef enum logic [1:0] {
    OP_WR   = 2'b00,
    OP_RD   = 2'b01,
    OP_BSR  = 2'b10,
    OP_MODE = 2'b11
  } ppi_op_e;

  localparam logic [1:0] REG_PA   = 2'd0;
  localparam logic [1:0] REG_PB   = 2'd1;
  localparam logic [1:0] REG_PC   = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } ppi_state_e;

  typedef struct packed {
    logic [1:0] a;
    logic [7:0] d;
  } ppi_bus_t;

  // Bit-set/reset and mode words both target the control register;
  // a read leaves the data bus at whatever it last carried.
  function automatic ppi_bus_t map_cmd(ppi_op_e op, logic [1:0] addr,
                                       logic [7:0] data, logic [7:0] d_prev);
    ppi_bus_t b;
    b.a = addr;
    b.d = d_prev;
    case (op)
      OP_WR:   b.d = data;
      OP_BSR: begin
        b.a = REG_CTRL;
        b.d = {4'b0000, data[3:1], data[0]};
      end
      OP_MODE: begin
        b.a = REG_CTRL;
        b.d = {1'b1, data[6:0]};
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nx1_ppi_master_if.sv
// Command handshake and PIA bus pins of the nx1 PIA bus initiator.
interface nx1_ppi_master_if;
  logic       I_CMD_VALID;
  logic       O_CMD_READY;
  logic [1:0] I_CMD_OP;
  logic [1:0] I_CMD_ADDR;
  logic [7:0] I_CMD_DATA;
  logic       O_DONE;
  logic [7:0] O_RDATA;
  logic [1:0] O_A;
  logic       O_CS;
  logic       O_WR;
  logic       O_RD;
  logic [7:0] O_D;
  logic [7:0] I_D;

  modport master (
    input  I_CMD_VALID, I_CMD_OP, I_CMD_ADDR, I_CMD_DATA, I_D,
    output O_CMD_READY, O_DONE, O_RDATA, O_A, O_CS, O_WR, O_RD, O_D
  );

  modport slave (
    output I_CMD_VALID, I_CMD_OP, I_CMD_ADDR, I_CMD_DATA, I_D,
    input  O_CMD_READY, O_DONE, O_RDATA, O_A, O_CS, O_WR, O_RD, O_D
  );
endinterface

// File: rtl/nx1_ppi_timer.sv
// Phase timer: loads a cycle count on phase entry, counts down, flags zero.
module nx1_ppi_timer
  import nx1_ppi_pkg::*;
(
  input  logic             I_CLK,
  input  logic             I_RESET,
  input  logic             I_LOAD,
  input  logic [TMR_W-1:0] I_LOAD_VAL,
  input  logic             I_DEC,
  output logic             O_ZERO
);

  logic [TMR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (I_LOAD) begin
      count_d = I_LOAD_VAL;
    end else if (I_DEC && (count_q != '0)) begin
      count_d = count_q - TMR_W'(1);
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign O_ZERO = (count_q == '0);

endmodule

// File: rtl/nx1_ppi_master.sv
// 8255 bus initiator: turns single valid/ready commands into timed
// CS/WR/RD/A/D cycles and returns read data with a DONE pulse.
module nx1_ppi_master
  import nx1_ppi_pkg::*;
#(
  parameter int unsigned T_SETUP   = 1,
  parameter int unsigned T_PULSE   = 2,
  parameter int unsigned T_HOLD    = 1,
  parameter int unsigned T_RECOVER = 1
) (
  input  logic              I_CLK,
  input  logic              I_RESET,
  nx1_ppi_master_if.master  bus
);

  localparam int unsigned PULSE_EFF = (T_PULSE == 0) ? 1 : T_PULSE;

  localparam logic [TMR_W-1:0] LD_SETUP   = TMR_W'((T_SETUP   > 0) ? T_SETUP   - 1 : 0);
  localparam logic [TMR_W-1:0] LD_PULSE   = TMR_W'(PULSE_EFF - 1);
  localparam logic [TMR_W-1:0] LD_HOLD    = TMR_W'((T_HOLD    > 0) ? T_HOLD    - 1 : 0);
  localparam logic [TMR_W-1:0] LD_RECOVER = TMR_W'((T_RECOVER > 0) ? T_RECOVER - 1 : 0);

  localparam ppi_state_e AFTER_IDLE  = (T_SETUP   > 0) ? ST_SETUP   : ST_STROBE;
  localparam ppi_state_e AFTER_HOLD  = (T_RECOVER > 0) ? ST_RECOVER : ST_IDLE;
  localparam ppi_state_e AFTER_STRB  = (T_HOLD    > 0) ? ST_HOLD    : AFTER_HOLD;

  ppi_state_e       state_q, state_d;
  ppi_op_e          op_q, op_d;
  logic [1:0]       a_q, a_d;
  logic [7:0]       d_q, d_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             cs_q, cs_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_zero;
  logic [TMR_W-1:0] tmr_val;
  ppi_bus_t         bus_w;

  nx1_ppi_timer u_timer (
    .I_CLK      (I_CLK),
    .I_RESET    (I_RESET),
    .I_LOAD     (tmr_load),
    .I_LOAD_VAL (tmr_val),
    .I_DEC      (tmr_dec),
    .O_ZERO     (tmr_zero)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    d_d     = d_q;
    rdata_d = rdata_q;
    tmr_dec = 1'b0;
    bus_w   = map_cmd(ppi_op_e'(bus.I_CMD_OP), bus.I_CMD_ADDR, bus.I_CMD_DATA, d_q);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.I_CMD_VALID) begin
          state_d = AFTER_IDLE;
          op_d    = ppi_op_e'(bus.I_CMD_OP);
          a_d     = bus_w.a;
          d_d     = bus_w.d;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) state_d = ST_STROBE;
        else          tmr_dec = 1'b1;
      end
      ST_STROBE: begin
        if (tmr_zero) begin
          state_d = AFTER_STRB;
          if (op_q == OP_RD) rdata_d = bus.I_D;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) state_d = AFTER_HOLD;
        else          tmr_dec = 1'b1;
      end
      ST_RECOVER: begin
        if (tmr_zero) state_d = ST_IDLE;
        else          tmr_dec = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Every phase transition reloads the timer with the new phase length.
    tmr_load = (state_d != state_q);
    unique case (state_d)
      ST_SETUP:   tmr_val = LD_SETUP;
      ST_STROBE:  tmr_val = LD_PULSE;
      ST_HOLD:    tmr_val = LD_HOLD;
      ST_RECOVER: tmr_val = LD_RECOVER;
      default:    tmr_val = '0;
    endcase

    // Pin levels are decoded from the next state so every output is a flop.
    cs_d    = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    wr_d    = (state_d == ST_STROBE) && (op_d != OP_RD);
    rd_d    = (state_d == ST_STROBE) && (op_d == OP_RD);
    done_d  = (state_d == ST_IDLE) && (state_q != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q <= ST_IDLE;
      op_q    <= OP_WR;
      a_q     <= '0;
      d_q     <= '0;
      rdata_q <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      d_q     <= d_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.O_CMD_READY = ready_q;
  assign bus.O_DONE      = done_q;
  assign bus.O_RDATA     = rdata_q;
  assign bus.O_A         = a_q;
  assign bus.O_D         = d_q;
  assign bus.O_CS        = cs_q;
  assign bus.O_WR        = wr_q;
  assign bus.O_RD        = rd_q;

endmodule

// File: tb/tb_nx1_ppi_master.sv
// Bench for nx1_ppi_master: default timing and all-minimum timing instances
// checked cycle by cycle against a transaction-offset reference model.
module tb_nx1_ppi_master;

  typedef struct packed {
    logic       valid;
    logic [1:0] op;
    logic [1:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef struct packed {
    logic       cs, wr, rd, done, ready;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] rdata;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nx1_ppi_master_if bus0 ();
  nx1_ppi_master_if bus1 ();

  nx1_ppi_master #(.T_SETUP(1), .T_PULSE(2), .T_HOLD(1), .T_RECOVER(1)) dut0 (
    .I_CLK(clk), .I_RESET(rst), .bus(bus0.master)
  );
  nx1_ppi_master #(.T_SETUP(0), .T_PULSE(1), .T_HOLD(0), .T_RECOVER(0)) dut1 (
    .I_CLK(clk), .I_RESET(rst), .bus(bus1.master)
  );

  int ts[2] = '{1, 0};
  int tp[2] = '{2, 1};
  int th[2] = '{1, 0};
  int tr[2] = '{1, 0};

  cmd_t       drv[2];
  logic [7:0] drv_id[2];

  assign bus0.I_CMD_VALID = drv[0].valid;
  assign bus0.I_CMD_OP    = drv[0].op;
  assign bus0.I_CMD_ADDR  = drv[0].addr;
  assign bus0.I_CMD_DATA  = drv[0].data;
  assign bus0.I_D         = drv_id[0];
  assign bus1.I_CMD_VALID = drv[1].valid;
  assign bus1.I_CMD_OP    = drv[1].op;
  assign bus1.I_CMD_ADDR  = drv[1].addr;
  assign bus1.I_CMD_DATA  = drv[1].data;
  assign bus1.I_D         = drv_id[1];

  // Reference model: cycles elapsed since acceptance (0 = idle, per = DONE cycle)
  int         mk[2];
  logic [1:0] mop[2];
  logic [1:0] ma[2];
  logic [7:0] md[2];
  logic [7:0] mrd[2];

  cmd_t cq[2][$];
  bit   rnd[2];
  bit   id_dir[2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int acc0[$];
  int acc1[$];
  int rd_hi, wr_hi;

  logic       pia_prev;
  logic [7:0] pia_pa, pia_pb, pia_pc, pia_ctrl;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string tg(int i, string s);
    return $sformatf("d%0d_c%0d_%s", i, cyc, s);
  endfunction

  function automatic int per(int i);
    return 1 + ts[i] + ((tp[i] == 0) ? 1 : tp[i]) + th[i] + tr[i];
  endfunction

  function automatic outs_t get_outs(int i);
    outs_t o;
    if (i == 0) begin
      o.cs = bus0.O_CS; o.wr = bus0.O_WR; o.rd = bus0.O_RD;
      o.done = bus0.O_DONE; o.ready = bus0.O_CMD_READY;
      o.a = bus0.O_A; o.d = bus0.O_D; o.rdata = bus0.O_RDATA;
    end else begin
      o.cs = bus1.O_CS; o.wr = bus1.O_WR; o.rd = bus1.O_RD;
      o.done = bus1.O_DONE; o.ready = bus1.O_CMD_READY;
      o.a = bus1.O_A; o.d = bus1.O_D; o.rdata = bus1.O_RDATA;
    end
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mk[i] = 0; mop[i] = 2'b00; ma[i] = 2'b00; md[i] = 8'h00; mrd[i] = 8'h00;
      drv[i] = '0;
      cq[i].delete();
    end
  endtask

  // One clock: compare both DUTs with the model, drive next inputs, advance model.
  task automatic cycle();
    outs_t o;
    cmd_t  c;
    int    k, s, p, h;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      o = get_outs(i);
      k = mk[i]; s = ts[i]; p = (tp[i] == 0) ? 1 : tp[i]; h = th[i];
      chk(tg(i, "cs"),    32'(o.cs),    32'(k >= 1 && k <= s + p + h));
      chk(tg(i, "wr"),    32'(o.wr),    32'(k >= s + 1 && k <= s + p && mop[i] != 2'd1));
      chk(tg(i, "rd"),    32'(o.rd),    32'(k >= s + 1 && k <= s + p && mop[i] == 2'd1));
      chk(tg(i, "done"),  32'(o.done),  32'(k == per(i)));
      chk(tg(i, "ready"), 32'(o.ready), 32'(k == 0 || k == per(i)));
      chk(tg(i, "a"),     32'(o.a),     32'(ma[i]));
      chk(tg(i, "d"),     32'(o.d),     32'(md[i]));
      chk(tg(i, "rdata"), 32'(o.rdata), 32'(mrd[i]));
      chk(tg(i, "wr_and_rd"),   32'(o.wr & o.rd), 32'd0);
      chk(tg(i, "strobe_nocs"), 32'((o.wr | o.rd) & ~o.cs), 32'd0);

      if (rnd[i]) begin
        c.valid = ($urandom_range(0, 1) == 1);
        c.op    = 2'($urandom);
        c.addr  = 2'($urandom);
        c.data  = 8'($urandom);
      end else if (cq[i].size() > 0) begin
        c = cq[i][0];
        c.valid = 1'b1;
      end else begin
        c = '0;
      end
      drv[i] = c;
      if (id_dir[i]) drv_id[i] = (k >= s + 1 && k <= s + p) ? 8'h3C : 8'hFF;
      else           drv_id[i] = 8'($urandom);

      if (k == s + p && mop[i] == 2'd1) mrd[i] = drv_id[i];
      if (k == 0 || k == per(i)) begin
        if (c.valid) begin
          mk[i]  = 1;
          mop[i] = c.op;
          case (c.op)
            2'd0: begin ma[i] = c.addr; md[i] = c.data; end
            2'd1: ma[i] = c.addr;
            2'd2: begin ma[i] = 2'd3; md[i] = c.data & 8'h0F; end
            default: begin ma[i] = 2'd3; md[i] = c.data | 8'h80; end
          endcase
          if (!rnd[i]) void'(cq[i].pop_front());
        end else begin
          mk[i] = 0;
        end
      end else begin
        mk[i] = k + 1;
      end
    end
  endtask

  task automatic run_idle(int max);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while ((cq[0].size() != 0 || cq[1].size() != 0 || mk[0] != 0 || mk[1] != 0) && n < max);
    chk($sformatf("drain_c%0d", cyc),
        32'(cq[0].size() == 0 && cq[1].size() == 0 && mk[0] == 0 && mk[1] == 0), 32'd1);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst && bus0.I_CMD_VALID && bus0.O_CMD_READY) acc0.push_back(cyc);
    if (!rst && bus1.I_CMD_VALID && bus1.O_CMD_READY) acc1.push_back(cyc);
  end

  always @(negedge clk) begin
    if (bus0.O_RD) rd_hi++;
    if (bus0.O_WR) wr_hi++;
    // PIA latches on the falling edge of CS&WR
    if (pia_prev && !(bus0.O_CS && bus0.O_WR)) begin
      case (bus0.O_A)
        2'd0: pia_pa = bus0.O_D;
        2'd1: pia_pb = bus0.O_D;
        2'd2: pia_pc = bus0.O_D;
        default: begin
          if (bus0.O_D[7]) pia_ctrl = bus0.O_D;
          else             pia_pc[bus0.O_D[3:1]] = bus0.O_D[0];
        end
      endcase
    end
    pia_prev = bus0.O_CS && bus0.O_WR;
  end

  initial begin
    outs_t o;
    int    n;
    pia_prev = 1'b0; pia_pa = '0; pia_pb = '0; pia_pc = '0; pia_ctrl = '0;
    rd_hi = 0; wr_hi = 0;
    rnd[0] = 0; rnd[1] = 0; id_dir[0] = 0; id_dir[1] = 0;
    drv_id[0] = '0; drv_id[1] = '0;
    model_reset();

    #1 rst = 1'b1;
    #7;
    for (int i = 0; i < 2; i++) begin
      o = get_outs(i);
      chk($sformatf("d%0d_reset_outs", i), 32'({o.cs, o.wr, o.rd, o.done, o.a, o.d, o.rdata}), 32'd0);
      chk($sformatf("d%0d_reset_ready", i), 32'(o.ready), 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;

    // write PB = A5 with default timing
    cq[0].push_back('{1'b1, 2'b00, 2'd1, 8'hA5});
    run_idle(40);
    chk("pia_pb_a5", 32'(pia_pb), 32'hA5);

    // read PC: 3C during strobe, FF afterwards
    id_dir[0] = 1; rd_hi = 0; wr_hi = 0;
    cq[0].push_back('{1'b1, 2'b01, 2'd2, 8'h00});
    run_idle(40);
    id_dir[0] = 0;
    chk("read_rdata", 32'(bus0.O_RDATA), 32'h3C);
    chk("read_rd_len", 32'(rd_hi), 32'd2);
    chk("read_no_wr", 32'(wr_hi), 32'd0);

    // bit set PC5, then mode word
    pia_pc = 8'h00;
    cq[0].push_back('{1'b1, 2'b10, 2'd0, 8'h0B});
    cq[0].push_back('{1'b1, 2'b11, 2'd1, 8'h12});
    run_idle(40);
    chk("pia_pc_bit5", 32'(pia_pc[5]), 32'd1);
    chk("pia_mode", 32'(pia_ctrl), 32'h92);
    chk("rdata_kept", 32'(bus0.O_RDATA), 32'h3C);

    // valid held for three commands on both timing sets
    acc0.delete(); acc1.delete();
    for (int j = 0; j < 3; j++) begin
      cq[0].push_back('{1'b1, 2'b00, 2'(j), 8'(8'h10 + j)});
      cq[1].push_back('{1'b1, 2'b00, 2'(j), 8'(8'h20 + j)});
    end
    run_idle(60);
    chk("acc0_count", 32'(acc0.size()), 32'd3);
    chk("acc1_count", 32'(acc1.size()), 32'd3);
    for (int j = 1; j < 3; j++) begin
      if (j < acc0.size()) chk($sformatf("acc0_gap%0d", j), 32'(acc0[j] - acc0[j-1]), 32'd6);
      if (j < acc1.size()) chk($sformatf("acc1_gap%0d", j), 32'(acc1[j] - acc1[j-1]), 32'd2);
    end

    // reset in the second strobe cycle of a write
    cq[0].push_back('{1'b1, 2'b00, 2'd0, 8'h5A});
    n = 0;
    do begin cycle(); n++; end while (mk[0] != 3 && n < 20);
    chk("rst_reach_strobe2", 32'(mk[0]), 32'd3);
    @(posedge clk);
    #1;
    chk("rst_pre_wr", 32'(bus0.O_WR), 32'd1);
    chk("rst_pre_cs", 32'(bus0.O_CS), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_cs",    32'(bus0.O_CS), 32'd0);
    chk("rst_wr",    32'(bus0.O_WR), 32'd0);
    chk("rst_done",  32'(bus0.O_DONE), 32'd0);
    chk("rst_rdata", 32'(bus0.O_RDATA), 32'd0);
    chk("rst_ready", 32'(bus0.O_CMD_READY), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) cycle();

    // random traffic on both instances
    rnd[0] = 1; rnd[1] = 1;
    repeat (800) cycle();
    rnd[0] = 0; rnd[1] = 0;
    run_idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
